// File: rtl/i_ref_dac_pkg.sv
// Shared types and constants for the current-reference DAC driver.
// Used by i_ref_dac_driver; see that file for the I_REF_SLEW_LIMIT_EN option.
package i_ref_dac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CS_HOLD = 2'd2,
        LDAC    = 2'd3
    } state_e;

    localparam logic [3:0] CMD_WRITE_DEF = 4'b0011;

    function automatic int frame_bits(input int cmd_bits, input int dac_width);
        return cmd_bits + dac_width;
    endfunction

endpackage

// File: rtl/i_ref_dac_driver_sclk_gen.sv
// Serial clock generator: CLK_DIV clk cycles per sclk half-period, idles low
// while disabled, and flags the clk cycle on which sclk is about to rise/fall.
module sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             tc;

    assign tc   = en && (cnt_q == '0);
    assign rise = tc && !sclk_q;
    assign fall = tc && sclk_q;
    assign sclk = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = CNT_LOAD;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = CNT_LOAD;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= CNT_LOAD;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/i_ref_dac_driver.sv
// Sends i_ref to an external serial DAC (SPI mode 0 + LDAC strobe) whenever it
// differs from the last loaded code. Define I_REF_SLEW_LIMIT_EN to cap each step at MAX_STEP.
//
// state   | meaning
// IDLE    | link quiet; start a frame when enabled and i_ref != dac_value
// SHIFT   | clocking FRAME_BITS bits out MSB first
// CS_HOLD | cs_n held low for CLK_DIV cycles after the last falling sclk
// LDAC    | ldac_n low for CLK_DIV cycles, then commit dac_value and pulse done
module i_ref_dac_driver
    import i_ref_dac_pkg::*;
#(
    parameter int                  BUS_WIDTH = 10,
    parameter int                  DAC_WIDTH = 12,
    parameter int                  CMD_BITS  = 4,
    parameter logic [CMD_BITS-1:0] CMD_WRITE = CMD_BITS'(CMD_WRITE_DEF),
    parameter int                  CLK_DIV   = 2,
    parameter int                  MAX_STEP  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi,
    output logic                 ldac_n,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] dac_value
);

    localparam int FRAME_BITS = frame_bits(CMD_BITS, DAC_WIDTH);
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int HOLD_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CLK_DIV - 1);

    if (DAC_WIDTH < BUS_WIDTH) begin : g_bad_width
        $error("DAC_WIDTH must be >= BUS_WIDTH");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be >= 1");
    end
    if (MAX_STEP < 1) begin : g_bad_step
        $error("MAX_STEP must be >= 1");
    end

    state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [BUS_WIDTH-1:0]   send_code_q, send_code_d;
    logic [BUS_WIDTH-1:0]   dac_value_q, dac_value_d;
    logic                   cs_n_q, cs_n_d;
    logic                   mosi_q, mosi_d;
    logic                   ldac_n_q, ldac_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [BUS_WIDTH-1:0]   send_code_c;
    logic [FRAME_BITS-1:0]  frame_c;
    logic                   sclk_rise, sclk_fall;

`ifdef I_REF_SLEW_LIMIT_EN
    localparam logic signed [BUS_WIDTH:0] STEP_S = (BUS_WIDTH + 1)'(MAX_STEP);
    localparam logic [BUS_WIDTH-1:0]      STEP_U = BUS_WIDTH'(MAX_STEP);
    logic signed [BUS_WIDTH:0] diff_c;

    // One extra bit keeps the signed difference exact for any pair of codes.
    always_comb begin
        diff_c = $signed({1'b0, i_ref}) - $signed({1'b0, dac_value_q});
        if (diff_c > STEP_S) begin
            send_code_c = dac_value_q + STEP_U;
        end else if (diff_c < -STEP_S) begin
            send_code_c = dac_value_q - STEP_U;
        end else begin
            send_code_c = i_ref;
        end
    end
`else
    assign send_code_c = i_ref;
`endif

    // Code is left-justified in the DAC field; unused LSBs shift in as zeros.
    assign frame_c = FRAME_BITS'({CMD_WRITE, send_code_c}) << (DAC_WIDTH - BUS_WIDTH);

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == SHIFT),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        send_code_d = send_code_q;
        dac_value_d = dac_value_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        ldac_n_d    = ldac_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cs_n_d   = 1'b1;
                ldac_n_d = 1'b1;
                busy_d   = 1'b0;
                if (enable && (i_ref != dac_value_q)) begin
                    send_code_d = send_code_c;
                    shift_d     = frame_c;
                    mosi_d      = frame_c[FRAME_BITS-1];
                    bit_cnt_d   = BIT_W'(FRAME_BITS);
                    cs_n_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
                // The DAC has sampled every bit once the counter is empty.
                if (sclk_fall) begin
                    shift_d = shift_q << 1;
                    mosi_d  = shift_q[FRAME_BITS-2];
                    if (bit_cnt_q == '0) begin
                        mosi_d     = 1'b0;
                        hold_cnt_d = HOLD_LOAD;
                        state_d    = CS_HOLD;
                    end
                end
            end
            CS_HOLD: begin
                if (hold_cnt_q == '0) begin
                    cs_n_d     = 1'b1;
                    ldac_n_d   = 1'b0;
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = LDAC;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            LDAC: begin
                if (hold_cnt_q == '0) begin
                    ldac_n_d    = 1'b1;
                    dac_value_d = send_code_q;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            send_code_q <= '0;
            dac_value_q <= '0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ldac_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            send_code_q <= send_code_d;
            dac_value_q <= dac_value_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            ldac_n_q    <= ldac_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;
    assign ldac_n    = ldac_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dac_value = dac_value_q;

endmodule

// File: tb/tb_i_ref_dac_driver.sv
// Self-checking bench for i_ref_dac_driver with default parameters; honours I_REF_SLEW_LIMIT_EN.
module tb_i_ref_dac_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] i_ref;
    logic       sclk, cs_n, mosi, ldac_n, busy, done;
    logic [9:0] dac_value;

    int total = 0;
    int bad   = 0;

    i_ref_dac_driver dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .i_ref     (i_ref),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .ldac_n    (ldac_n),
        .busy      (busy),
        .done      (done),
        .dac_value (dac_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int starts = 0;
    always @(negedge cs_n) starts++;

    int sclk_rises = 0;
    always @(posedge sclk) sclk_rises++;

    // Serial capture as the DAC would see it: sample mosi on rising sclk while selected.
    logic [15:0] cap_sh = '0;
    int          cap_n  = 0;
    logic [15:0] frame_q[$];
    int          nbits_q[$];
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n === 1'b1) begin
            if (cap_n > 0) begin
                frame_q.push_back(cap_sh);
                nbits_q.push_back(cap_n);
            end
            cap_sh = '0;
            cap_n  = 0;
        end else begin
            cap_sh = {cap_sh[14:0], mosi};
            cap_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_frame(input int code);
        return 16'((3 << 12) + code * 4);
    endfunction

    // Next code loaded into the DAC when heading from cur toward tgt.
    function automatic int model_step(input int tgt, input int cur);
`ifdef I_REF_SLEW_LIMIT_EN
        if (tgt - cur > 64)  return cur + 64;
        if (cur - tgt > 64)  return cur - 64;
`endif
        return tgt;
    endfunction

    task automatic wait_start(output int c);
        bit ok = 0;
        c = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (cs_n === 1'b0) begin
                ok = 1;
                c  = cyc;
            end
        end
        check("start_seen", 32'(ok), 1);
    endtask

    task automatic wait_done(output int c);
        bit ok = 0;
        c = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                c  = cyc;
            end
        end
        check("done_seen", 32'(ok), 1);
    endtask

    task automatic check_frame(input string tag, input int code);
        logic [15:0] f;
        int          n;
        check({tag, "_frame_cnt"}, 32'(frame_q.size()), 1);
        if (frame_q.size() > 0) begin
            f = frame_q.pop_front();
            n = nbits_q.pop_front();
            check({tag, "_frame"}, 32'(f), 32'(exp_frame(code)));
            check({tag, "_bits"}, 32'(n), 16);
        end
        frame_q.delete();
        nbits_q.delete();
    endtask

    initial begin
        int s, d, s2, st0, rs0, cur, tgt, nexp;
        int exp_codes[$];

        rst    = 1'b0;
        enable = 1'b1;
        i_ref  = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_ldac_n", 32'(ldac_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dac_value", 32'(dac_value), 0);
        rst = 1'b1;
        frame_q.delete();
        nbits_q.delete();

        // i_ref == 0 after reset: the link must stay quiet.
        st0 = starts;
        rs0 = sclk_rises;
        repeat (200) @(negedge clk);
        check("quiet_starts", 32'(starts - st0), 0);
        check("quiet_sclk", 32'(sclk_rises - rs0), 0);
        check("quiet_cs_n", 32'(cs_n), 1);
        check("quiet_busy", 32'(busy), 0);
        check("quiet_dac_value", 32'(dac_value), 0);

`ifndef I_REF_SLEW_LIMIT_EN
        // Single frame, latency and content.
        i_ref = 10'h2AB;
        wait_start(s);
        check("f1_busy", 32'(busy), 1);
        wait_done(d);
        check("f1_latency", 32'(d - s), 68);
        check_frame("f1", 10'h2AB);
        check("f1_dac_value", 32'(dac_value), 32'h2AB);
        check("f1_ldac_n", 32'(ldac_n), 1);
        @(negedge clk);
        check("f1_done_pulse", 32'(done), 0);
        check("f1_busy_after", 32'(busy), 0);

        // Move away, then come back with a mid-frame change of i_ref.
        i_ref = 10'h155;
        wait_done(d);
        check_frame("f2", 10'h155);
        i_ref = 10'h2AB;
        wait_start(s);
        repeat (20) @(negedge clk);
        i_ref = 10'h100;
        wait_done(d);
        check_frame("f3", 10'h2AB);
        check("f3_dac_value", 32'(dac_value), 32'h2AB);
        wait_start(s2);
        check("f4_period", 32'(s2 - s), 69);
        wait_done(d);
        check_frame("f4", 10'h100);
        check("f4_dac_value", 32'(dac_value), 32'h100);

        // enable dropped mid-frame: frame completes, nothing further starts.
        i_ref = 10'h3FF;
        wait_start(s);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_done(d);
        check("f5_latency", 32'(d - s), 68);
        check_frame("f5", 10'h3FF);
        check("f5_dac_value", 32'(dac_value), 32'h3FF);
        i_ref = 10'h001;
        st0 = starts;
        repeat (150) @(negedge clk);
        check("dis_starts", 32'(starts - st0), 0);
        check("dis_dac_value", 32'(dac_value), 32'h3FF);
`else
        i_ref = 10'h001;
`endif

        // Reset in the middle of a frame.
        enable = 1'b1;
        wait_start(s);
        repeat (30) @(negedge clk);
        check("mid_busy_before", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("midrst_cs_n", 32'(cs_n), 1);
        check("midrst_sclk", 32'(sclk), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ldac_n", 32'(ldac_n), 1);
        check("midrst_dac_value", 32'(dac_value), 0);
        i_ref = '0;
        @(negedge clk);
        rst = 1'b1;
        frame_q.delete();
        nbits_q.delete();
        repeat (5) @(negedge clk);
        cur = 0;

`ifdef I_REF_SLEW_LIMIT_EN
        // Slew-limited step 0 -> 200.
        i_ref = 10'd200;
        foreach (exp_codes[k]) exp_codes.delete(k);
        exp_codes = '{64, 128, 192, 200};
        foreach (exp_codes[k]) begin
            wait_done(d);
            check_frame("slew", exp_codes[k]);
            check("slew_dac_value", 32'(dac_value), 32'(exp_codes[k]));
        end
        st0 = starts;
        repeat (150) @(negedge clk);
        check("slew_idle", 32'(starts - st0), 0);
        cur = 200;
`endif

        // Randomized targets against the model.
        for (int it = 0; it < 10; it++) begin
            tgt = (it == 3) ? cur : int'($urandom_range(0, 1023));
            exp_codes.delete();
            begin
                int c = cur;
                while (c != tgt) begin
                    c = model_step(tgt, c);
                    exp_codes.push_back(c);
                end
            end
            nexp = exp_codes.size();
            st0 = starts;
            i_ref = 10'(tgt);
            foreach (exp_codes[k]) begin
                wait_done(d);
                check_frame("rnd", exp_codes[k]);
                check("rnd_dac_value", 32'(dac_value), 32'(exp_codes[k]));
            end
            repeat (80) @(negedge clk);
            check("rnd_starts", 32'(starts - st0), 32'(nexp));
            check("rnd_final", 32'(dac_value), 32'(tgt));
            check("rnd_idle_busy", 32'(busy), 0);
            cur = tgt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
